ex_stage: RTL and testbench

Execute stage of the five-stage RV32I pipeline. Consumes the ID/EX bundle driven by `IFID_top`, performs ALU operations and branch/jump resolution, and returns `pc_src`/`pc_target` to the fetch side. Registers results into the EX/MEM pipeline register. Squashes the one wrong-path instruction that reaches EX after a taken redirect.

---
 rtl/ex_stage.sv | 230 +++++++++++++++++++++++
 tb/tb_ex_stage.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Purpose  : Execute stage of the five-stage RV32I pipeline. Performs ALU
//            operations and branch/jump resolution, drives the fetch
//            redirect (pc_src/pc_target) combinationally, and registers
//            results into the EX/MEM pipeline register. One wrong-path
//            instruction reaching EX after a taken redirect is squashed.
// Ports    : clk, reset (async, active-low)
//            *_E          ID/EX bundle (control, operands, PCs, indices)
//            rd_W, reg_we_W, wb_data_W   writeback forwarding source
//            pc_src, pc_target           fetch redirect (combinational)
//            *_M          EX/MEM pipeline register outputs
// Config   : EX_FORWARDING_EN - when defined, rs1/rs2 are forwarded from
//            EX/MEM (priority) or WB; otherwise the WB ports are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage #(
  parameter int XLEN = 32,
  parameter int PCW  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            reg_we_E,
  input  logic            mem_we_E,
  input  logic            mem_re_E,
  input  logic            branch_E,
  input  logic            mem_to_reg_E,
  input  logic            alu_src_E,
  input  logic [6:0]      ALU_control_E,
  input  logic [2:0]      mem_read_type_E,
  input  logic [1:0]      mem_store_type_E,
  input  logic [4:0]      rs1_E,
  input  logic [4:0]      rs2_E,
  input  logic [4:0]      rd_E,
  input  logic [XLEN-1:0] imm32_final_E,
  input  logic [XLEN-1:0] read_reg1_E,
  input  logic [XLEN-1:0] read_reg2_E,
  input  logic [PCW-1:0]  pc_E,
  input  logic [PCW-1:0]  pc_plus4_E,
  input  logic [PCW-1:0]  dest_pc_E,
  input  logic [4:0]      rd_W,
  input  logic            reg_we_W,
  input  logic [XLEN-1:0] wb_data_W,
  output logic            pc_src,
  output logic [PCW-1:0]  pc_target,
  output logic            reg_we_M,
  output logic            mem_we_M,
  output logic            mem_re_M,
  output logic            mem_to_reg_M,
  output logic [2:0]      mem_read_type_M,
  output logic [1:0]      mem_store_type_M,
  output logic [4:0]      rd_M,
  output logic [XLEN-1:0] alu_result_M,
  output logic [XLEN-1:0] write_data_M,
  output logic [PCW-1:0]  pc_plus4_M
);

  localparam logic [2:0] c_cls_arith = 3'd0;
  localparam logic [2:0] c_cls_lui   = 3'd1;
  localparam logic [2:0] c_cls_auipc = 3'd2;
  localparam logic [2:0] c_cls_jal   = 3'd3;
  localparam logic [2:0] c_cls_jalr  = 3'd4;
  localparam logic [2:0] c_cls_br    = 3'd5;
  localparam logic [2:0] c_cls_ldst  = 3'd6;

  localparam logic [0:0] c_st_normal = 1'b0;
  localparam logic [0:0] c_st_squash = 1'b1;

  logic [0:0]      r_state;
  logic [0:0]      w_state_next;
  logic            w_squash;

  logic [XLEN-1:0] w_fwd_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_op_b;
  logic [XLEN-1:0] w_result;
  logic [PCW-1:0]  w_jalr_sum;
  logic            w_br_taken;
  logic            w_redirect_raw;

  logic [2:0]      w_funct3;
  logic            w_f7b5;
  logic [2:0]      w_cls;
  logic [4:0]      w_shamt;

  assign w_funct3 = ALU_control_E[6:4];
  assign w_f7b5   = ALU_control_E[3];
  assign w_cls    = ALU_control_E[2:0];

  // --------------------------------------------------------------------------
  // Operand selection
  // --------------------------------------------------------------------------
`ifdef EX_FORWARDING_EN
  // EX/MEM wins over WB; register x0 is never forwarded.
  always_comb begin
    w_fwd_a = read_reg1_E;
    if (reg_we_M && (rd_M == rs1_E) && (rs1_E != 5'd0))
      w_fwd_a = alu_result_M;
    else if (reg_we_W && (rd_W == rs1_E) && (rs1_E != 5'd0))
      w_fwd_a = wb_data_W;
  end

  always_comb begin
    w_fwd_b = read_reg2_E;
    if (reg_we_M && (rd_M == rs2_E) && (rs2_E != 5'd0))
      w_fwd_b = alu_result_M;
    else if (reg_we_W && (rd_W == rs2_E) && (rs2_E != 5'd0))
      w_fwd_b = wb_data_W;
  end
`else
  assign w_fwd_a = read_reg1_E;
  assign w_fwd_b = read_reg2_E;

  // Forwarding inputs stay on the port list but carry no meaning here.
  logic w_unused_fwd;
  assign w_unused_fwd = ^{rd_W, reg_we_W, wb_data_W, rs1_E, rs2_E};
`endif

  assign w_op_b  = alu_src_E ? imm32_final_E : w_fwd_b;
  assign w_shamt = w_op_b[4:0];

  // --------------------------------------------------------------------------
  // ALU
  // --------------------------------------------------------------------------
  always_comb begin
    w_result = '0;
    case (w_cls)
      c_cls_arith: begin
        case (w_funct3)
          3'd0: w_result = (w_f7b5 && !alu_src_E) ? (w_fwd_a - w_op_b)
                                                  : (w_fwd_a + w_op_b);
          3'd1: w_result = w_fwd_a << w_shamt;
          3'd2: w_result = {{(XLEN-1){1'b0}}, ($signed(w_fwd_a) < $signed(w_op_b))};
          3'd3: w_result = {{(XLEN-1){1'b0}}, (w_fwd_a < w_op_b)};
          3'd4: w_result = w_fwd_a ^ w_op_b;
          3'd5: w_result = w_f7b5 ? XLEN'($signed(w_fwd_a) >>> w_shamt)
                                  : (w_fwd_a >> w_shamt);
          3'd6: w_result = w_fwd_a | w_op_b;
          default: w_result = w_fwd_a & w_op_b;
        endcase
      end
      c_cls_lui:   w_result = imm32_final_E;
      c_cls_auipc: w_result = {{(XLEN-PCW){1'b0}}, pc_E} + imm32_final_E;
      c_cls_jal,
      c_cls_jalr:  w_result = {{(XLEN-PCW){1'b0}}, pc_plus4_E};
      c_cls_ldst:  w_result = w_fwd_a + imm32_final_E;
      default:     w_result = '0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Branch / jump resolution
  // --------------------------------------------------------------------------
  always_comb begin
    w_br_taken = 1'b0;
    if (branch_E && (w_cls == c_cls_br)) begin
      case (w_funct3)
        3'd0:    w_br_taken = (w_fwd_a == w_fwd_b);
        3'd1:    w_br_taken = (w_fwd_a != w_fwd_b);
        3'd4:    w_br_taken = ($signed(w_fwd_a) <  $signed(w_fwd_b));
        3'd5:    w_br_taken = ($signed(w_fwd_a) >= $signed(w_fwd_b));
        3'd6:    w_br_taken = (w_fwd_a <  w_fwd_b);
        3'd7:    w_br_taken = (w_fwd_a >= w_fwd_b);
        default: w_br_taken = 1'b0;
      endcase
    end
  end

  assign w_redirect_raw = w_br_taken || (w_cls == c_cls_jal) || (w_cls == c_cls_jalr);
  assign w_jalr_sum     = w_fwd_a[PCW-1:0] + imm32_final_E[PCW-1:0];

  // pc_src is also held low while reset is asserted so fetch never sees a
  // redirect from a stage that is being cleared.
  assign pc_src    = reset && !w_squash && w_redirect_raw;
  assign pc_target = (w_cls == c_cls_jalr) ? (w_jalr_sum & ~{{(PCW-1){1'b0}}, 1'b1})
                                           : dest_pc_E;

  // --------------------------------------------------------------------------
  // Squash FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_st_normal;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_normal: if (pc_src) w_state_next = c_st_squash;
      default:     w_state_next = c_st_normal;
    endcase
  end

  always_comb begin
    w_squash = (r_state == c_st_squash);
  end

  // --------------------------------------------------------------------------
  // EX/MEM pipeline register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_we_M         <= 1'b0;
      mem_we_M         <= 1'b0;
      mem_re_M         <= 1'b0;
      mem_to_reg_M     <= 1'b0;
      mem_read_type_M  <= '0;
      mem_store_type_M <= '0;
      rd_M             <= '0;
      alu_result_M     <= '0;
      write_data_M     <= '0;
      pc_plus4_M       <= '0;
    end else begin
      // A squashed slot keeps flowing but with every side effect disabled.
      reg_we_M         <= reg_we_E     && !w_squash;
      mem_we_M         <= mem_we_E     && !w_squash;
      mem_re_M         <= mem_re_E     && !w_squash;
      mem_to_reg_M     <= mem_to_reg_E && !w_squash;
      mem_read_type_M  <= mem_read_type_E;
      mem_store_type_M <= mem_store_type_E;
      rd_M             <= rd_E;
      alu_result_M     <= w_result;
      write_data_M     <= w_fwd_b;
      pc_plus4_M       <= pc_plus4_E;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Purpose  : Self-checking bench for ex_stage. Directed scenarios followed by
//            randomized instructions compared against a behavioural model of
//            the execute stage (ALU, branch, redirect, squash, forwarding).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_we_E, mem_we_E, mem_re_E, branch_E, mem_to_reg_E, alu_src_E;
  logic [6:0]  ALU_control_E;
  logic [2:0]  mem_read_type_E;
  logic [1:0]  mem_store_type_E;
  logic [4:0]  rs1_E, rs2_E, rd_E;
  logic [31:0] imm32_final_E, read_reg1_E, read_reg2_E;
  logic [15:0] pc_E, pc_plus4_E, dest_pc_E;
  logic [4:0]  rd_W;
  logic        reg_we_W;
  logic [31:0] wb_data_W;
  logic        pc_src;
  logic [15:0] pc_target;
  logic        reg_we_M, mem_we_M, mem_re_M, mem_to_reg_M;
  logic [2:0]  mem_read_type_M;
  logic [1:0]  mem_store_type_M;
  logic [4:0]  rd_M;
  logic [31:0] alu_result_M, write_data_M;
  logic [15:0] pc_plus4_M;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference-model view of the EX/MEM register and the squash slot.
  logic        m_reg_we, m_mem_we, m_mem_re, m_m2r, m_squash;
  logic [2:0]  m_rtype;
  logic [1:0]  m_stype;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_wd;
  logic [15:0] m_pc4;

  ex_stage #(.XLEN(32), .PCW(16)) u_dut (
    .clk(clk), .reset(reset),
    .reg_we_E(reg_we_E), .mem_we_E(mem_we_E), .mem_re_E(mem_re_E),
    .branch_E(branch_E), .mem_to_reg_E(mem_to_reg_E), .alu_src_E(alu_src_E),
    .ALU_control_E(ALU_control_E), .mem_read_type_E(mem_read_type_E),
    .mem_store_type_E(mem_store_type_E), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .rd_E(rd_E), .imm32_final_E(imm32_final_E), .read_reg1_E(read_reg1_E),
    .read_reg2_E(read_reg2_E), .pc_E(pc_E), .pc_plus4_E(pc_plus4_E),
    .dest_pc_E(dest_pc_E), .rd_W(rd_W), .reg_we_W(reg_we_W),
    .wb_data_W(wb_data_W), .pc_src(pc_src), .pc_target(pc_target),
    .reg_we_M(reg_we_M), .mem_we_M(mem_we_M), .mem_re_M(mem_re_M),
    .mem_to_reg_M(mem_to_reg_M), .mem_read_type_M(mem_read_type_M),
    .mem_store_type_M(mem_store_type_M), .rd_M(rd_M),
    .alu_result_M(alu_result_M), .write_data_M(write_data_M),
    .pc_plus4_M(pc_plus4_M)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_reg_we = 0; m_mem_we = 0; m_mem_re = 0; m_m2r = 0; m_squash = 0;
    m_rtype = 0; m_stype = 0; m_rd = 0; m_alu = 0; m_wd = 0; m_pc4 = 0;
  endtask

  task automatic check_m_outputs(input string sfx);
    check({"reg_we_M", sfx},     32'(reg_we_M),         32'(m_reg_we));
    check({"mem_we_M", sfx},     32'(mem_we_M),         32'(m_mem_we));
    check({"mem_re_M", sfx},     32'(mem_re_M),         32'(m_mem_re));
    check({"mem_to_reg_M", sfx}, 32'(mem_to_reg_M),     32'(m_m2r));
    check({"rtype_M", sfx},      32'(mem_read_type_M),  32'(m_rtype));
    check({"stype_M", sfx},      32'(mem_store_type_M), 32'(m_stype));
    check({"rd_M", sfx},         32'(rd_M),             32'(m_rd));
    check({"alu_result_M", sfx}, alu_result_M,          m_alu);
    check({"write_data_M", sfx}, write_data_M,          m_wd);
    check({"pc_plus4_M", sfx},   32'(pc_plus4_M),       32'(m_pc4));
  endtask

  // Evaluate the instruction currently on the EX inputs, check the redirect,
  // clock it, then check the EX/MEM register. Called at posedge+1.
  task automatic run_instr();
    logic [31:0] a, b2, b, res, sum;
    logic [2:0]  f3, cls;
    logic [4:0]  sh;
    logic        f7, redir, exp_src;
    logic [15:0] tgt;
    a  = read_reg1_E;
    b2 = read_reg2_E;
`ifdef EX_FORWARDING_EN
    if (rs1_E != 0 && m_reg_we && m_rd == rs1_E)          a = m_alu;
    else if (rs1_E != 0 && reg_we_W && rd_W == rs1_E)     a = wb_data_W;
    if (rs2_E != 0 && m_reg_we && m_rd == rs2_E)          b2 = m_alu;
    else if (rs2_E != 0 && reg_we_W && rd_W == rs2_E)     b2 = wb_data_W;
`endif
    b   = alu_src_E ? imm32_final_E : b2;
    f3  = ALU_control_E[6:4];
    f7  = ALU_control_E[3];
    cls = ALU_control_E[2:0];
    sh  = b[4:0];
    res = 0; redir = 0; tgt = dest_pc_E;
    case (cls)
      3'd0: case (f3)
        3'd0: res = (f7 && !alu_src_E) ? a - b : a + b;
        3'd1: res = a << sh;
        3'd2: res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        3'd3: res = (a < b) ? 32'd1 : 32'd0;
        3'd4: res = a ^ b;
        3'd5: res = (a >> sh) | ((f7 && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
        3'd6: res = a | b;
        default: res = a & b;
      endcase
      3'd1: res = imm32_final_E;
      3'd2: res = {16'h0, pc_E} + imm32_final_E;
      3'd3: begin res = {16'h0, pc_plus4_E}; redir = 1; end
      3'd4: begin
        res = {16'h0, pc_plus4_E}; redir = 1;
        sum = a + imm32_final_E;
        tgt = sum[15:0] & 16'hFFFE;
      end
      3'd5: if (branch_E) case (f3)
        3'd0: redir = (a == b2);
        3'd1: redir = (a != b2);
        3'd4: redir = (int'(a) <  int'(b2));
        3'd5: redir = (int'(a) >= int'(b2));
        3'd6: redir = (a <  b2);
        3'd7: redir = (a >= b2);
        default: redir = 0;
      endcase
      3'd6: res = a + imm32_final_E;
      default: res = 0;
    endcase
    exp_src = m_squash ? 1'b0 : redir;
    #1;
    check("pc_src", 32'(pc_src), 32'(exp_src));
    if (exp_src) check("pc_target", 32'(pc_target), 32'(tgt));
    @(posedge clk);
    #1;
    m_reg_we = reg_we_E && !m_squash;
    m_mem_we = mem_we_E && !m_squash;
    m_mem_re = mem_re_E && !m_squash;
    m_m2r    = mem_to_reg_E && !m_squash;
    m_rtype  = mem_read_type_E;
    m_stype  = mem_store_type_E;
    m_rd     = rd_E;
    m_alu    = res;
    m_wd     = b2;
    m_pc4    = pc_plus4_E;
    m_squash = exp_src;
    check_m_outputs("");
  endtask

  task automatic set_instr(input logic [2:0] cls, input logic [2:0] f3, input logic f7,
                           input logic asrc, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] imm, input logic we);
    ALU_control_E = {f3, f7, cls};
    alu_src_E = asrc; read_reg1_E = r1; read_reg2_E = r2; imm32_final_E = imm;
    reg_we_E = we; mem_we_E = 0; mem_re_E = 0; mem_to_reg_E = 0; branch_E = 0;
    mem_read_type_E = 3'd2; mem_store_type_E = 2'd1;
    rs1_E = 0; rs2_E = 0; rd_E = 5'd1;
    pc_E = 16'h0100; pc_plus4_E = 16'h0104; dest_pc_E = 16'h0200;
    rd_W = 0; reg_we_W = 0; wb_data_W = 0;
  endtask

  task automatic rand_inputs();
    reg_we_E = 1'($urandom); mem_we_E = 1'($urandom); mem_re_E = 1'($urandom);
    branch_E = 1'($urandom); mem_to_reg_E = 1'($urandom); alu_src_E = 1'($urandom);
    ALU_control_E = {3'($urandom), 1'($urandom), 3'($urandom_range(0, 6))};
    mem_read_type_E = 3'($urandom); mem_store_type_E = 2'($urandom);
    rs1_E = 5'($urandom_range(0, 3)); rs2_E = 5'($urandom_range(0, 3));
    rd_E  = 5'($urandom_range(0, 3));
    imm32_final_E = $urandom;
    read_reg1_E = ($urandom_range(0, 3) == 0) ? read_reg2_E : $urandom;
    read_reg2_E = $urandom;
    pc_E = 16'($urandom); pc_plus4_E = pc_E + 16'd4; dest_pc_E = 16'($urandom);
    rd_W = 5'($urandom_range(0, 3)); reg_we_W = 1'($urandom); wb_data_W = $urandom;
  endtask

  initial begin
    // Reset held for two cycles with a JAL on the inputs.
    reset = 1'b0;
    rand_inputs();
    ALU_control_E[2:0] = 3'd3;
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_pc_src", 32'(pc_src), 32'd0);
      check_m_outputs("_rst");
    end
    reset = 1'b1;

    // ADD, SUB, SRA
    set_instr(3'd0, 3'd0, 1'b0, 1'b0, 32'd7, 32'd10, 32'd0, 1'b1);
    run_instr();
    check("add_17", alu_result_M, 32'd17);
    set_instr(3'd0, 3'd0, 1'b1, 1'b0, 32'd7, 32'd10, 32'd0, 1'b1);
    run_instr();
    check("sub_neg3", alu_result_M, 32'hFFFF_FFFD);
    set_instr(3'd0, 3'd5, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 1'b1);
    run_instr();
    check("sra_4", alu_result_M, 32'hF800_0000);

    // Taken BEQ, then the squashed ADD
    set_instr(3'd5, 3'd0, 1'b0, 1'b0, 32'd5, 32'd5, 32'd0, 1'b0);
    branch_E = 1'b1; dest_pc_E = 16'h0040;
    #1;
    check("beq_pc_src", 32'(pc_src), 32'd1);
    check("beq_target", 32'(pc_target), 32'h0040);
    run_instr();
    set_instr(3'd0, 3'd0, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 1'b1);
    run_instr();
    check("squash_reg_we", 32'(reg_we_M), 32'd0);

    // JALR, then a taken branch in the squashed slot
    set_instr(3'd4, 3'd0, 1'b0, 1'b1, 32'h0103, 32'd0, 32'd4, 1'b1);
    pc_plus4_E = 16'h0010;
    #1;
    check("jalr_target", 32'(pc_target), 32'h0106);
    run_instr();
    check("jalr_link", alu_result_M, 32'h0000_0010);
    set_instr(3'd5, 3'd0, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 1'b0);
    branch_E = 1'b1;
    #1;
    check("b2b_pc_src", 32'(pc_src), 32'd0);
    run_instr();

    // Forwarding from EX/MEM
    set_instr(3'd0, 3'd0, 1'b0, 1'b0, 32'd3, 32'd4, 32'd0, 1'b1);
    rs1_E = 5'd1; rs2_E = 5'd2; rd_E = 5'd5;
    run_instr();
    set_instr(3'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    rs1_E = 5'd5; rs2_E = 5'd5; rd_E = 5'd6;
    run_instr();
`ifdef EX_FORWARDING_EN
    check("fwd_x5x5", alu_result_M, 32'd14);
`else
    check("nofwd_x5x5", alu_result_M, 32'd0);
`endif
    // rd = 0 is registered but never forwarded
    set_instr(3'd0, 3'd0, 1'b0, 1'b0, 32'd3, 32'd4, 32'd0, 1'b1);
    rd_E = 5'd0;
    run_instr();
    check("rd0_reg", 32'(rd_M), 32'd0);
    set_instr(3'd0, 3'd0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0, 1'b1);
    run_instr();
    check("rd0_nofwd", alu_result_M, 32'd2);

    // Priority: EX/MEM over WB, then WB alone
    set_instr(3'd0, 3'd0, 1'b0, 1'b0, 32'd1, 32'd0, 32'd0, 1'b1);
    rd_E = 5'd5;
    run_instr();
    set_instr(3'd0, 3'd0, 1'b0, 1'b0, 32'd9, 32'd0, 32'd0, 1'b1);
    rs1_E = 5'd5; rd_E = 5'd7; reg_we_W = 1'b1; rd_W = 5'd5; wb_data_W = 32'd2;
    run_instr();
`ifdef EX_FORWARDING_EN
    check("fwd_prio", alu_result_M, 32'd1);
`else
    check("nofwd_prio", alu_result_M, 32'd9);
`endif
    set_instr(3'd0, 3'd0, 1'b0, 1'b0, 32'd9, 32'd0, 32'd0, 1'b1);
    rs1_E = 5'd5; reg_we_W = 1'b1; rd_W = 5'd5; wb_data_W = 32'd2;
    run_instr();
`ifdef EX_FORWARDING_EN
    check("fwd_wb", alu_result_M, 32'd2);
`else
    check("nofwd_wb", alu_result_M, 32'd9);
`endif

    // Randomized instructions with an asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      if (i == 200) begin
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_reg_we", 32'(reg_we_M), 32'd0);
        check("async_rst_alu", alu_result_M, 32'd0);
        check("async_rst_rd", 32'(rd_M), 32'd0);
        check("async_rst_pc_src", 32'(pc_src), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        rand_inputs();
      end
      run_instr();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
